// File: rtl/cal_date_keeper.sv
// Calendar date register for the calendar renderer.
// Advances the date on the midnight tick. Tracks month length and the weekday of the 1st.
// A user "set date" request is validated first. The weekday of the 1st is then
// recomputed by walking forward from the epoch, one year or month per cycle.
module cal_date_keeper #(
  parameter int unsigned YEAR_MIN   = 2000,
  parameter int unsigned YEAR_MAX   = 2999,
  parameter int unsigned EPOCH_WDAY = 5
) (
  input  logic        clk_50_i,
  input  logic        rst_i,
  input  logic        day_tick_i,
  input  logic        set_valid_i,
  output logic        set_ready_o,
  input  logic [4:0]  set_day_i,
  input  logic [3:0]  set_month_i,
  input  logic [11:0] set_year_i,
  output logic        set_err_o,
  output logic        busy_o,
  output logic [4:0]  day_in_month_o,
  output logic [3:0]  month_o,
  output logic [11:0] year_o,
  output logic [4:0]  month_days_cnt_o,
  output logic [2:0]  month_first_day_o,
  output logic [2:0]  week_day_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WALK_Y,
    S_WALK_M,
    S_COMMIT
  } state_e;

  localparam logic [11:0] Y_MIN      = 12'(YEAR_MIN);
  localparam logic [11:0] Y_MAX      = 12'(YEAR_MAX);
  localparam logic [2:0]  EPOCH      = 3'(EPOCH_WDAY);
  localparam logic [1:0]  MIN_MOD4   = 2'(YEAR_MIN % 4);
  localparam logic [6:0]  MIN_MOD100 = 7'(YEAR_MIN % 100);
  localparam logic [8:0]  MIN_MOD400 = 9'(YEAR_MIN % 400);

  // Days in month m (0=Jan); leap selects the 29-day February.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd1:                    return leap ? 5'd29 : 5'd28;
      4'd3, 4'd5, 4'd8, 4'd10: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  // Month length 28..31 reduced mod 7 is simply length - 28.
  function automatic logic [2:0] len_mod7(input logic [4:0] len);
    return 3'(len - 5'd28);
  endfunction

  // (a + b) mod 7 for a, b in 0..6.
  function automatic logic [2:0] add_mod7(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction

  // v mod 7 for v in 0..55, by conditional subtraction of 28, 14 and 7.
  function automatic logic [2:0] mod7_small(input logic [5:0] v);
    logic [5:0] s;
    s = v;
    if (s >= 6'd28) s = s - 6'd28;
    if (s >= 6'd14) s = s - 6'd14;
    if (s >= 6'd7)  s = s - 6'd7;
    return s[2:0];
  endfunction

  function automatic logic leap_from_mods(input logic [1:0] m4, input logic [6:0] m100,
                                          input logic [8:0] m400);
    return (m4 == 2'd0) && ((m100 != 7'd0) || (m400 == 9'd0));
  endfunction

  // Leap test for a requested year without a divider. Centuries are found by
  // comparing against the small set of multiples of 100/400 that fit in 12 bits.
  function automatic logic leap_of_year(input logic [11:0] y);
    logic cent;
    logic quad;
    cent = 1'b0;
    quad = 1'b0;
    for (int i = 0; i <= 40; i++) if (y == 12'(i * 100)) cent = 1'b1;
    for (int i = 0; i <= 10; i++) if (y == 12'(i * 400)) quad = 1'b1;
    return (y[1:0] == 2'd0) && (!cent || quad);
  endfunction

  function automatic logic [6:0] inc_mod100(input logic [6:0] v);
    return (v == 7'd99) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [8:0] inc_mod400(input logic [8:0] v);
    return (v == 9'd399) ? 9'd0 : v + 9'd1;
  endfunction

  // Architectural date state
  state_e      state_q, state_d;
  logic [4:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;
  logic [4:0]  days_cnt_q, days_cnt_d;
  logic [2:0]  first_q, first_d;
  logic [2:0]  wday_q, wday_d;
  logic [1:0]  mod4_q, mod4_d;
  logic [6:0]  mod100_q, mod100_d;
  logic [8:0]  mod400_q, mod400_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        pending_q, pending_d;

  // Captured request and walk state
  logic [4:0]  sd_q, sd_d;
  logic [3:0]  sm_q, sm_d;
  logic [11:0] sy_q, sy_d;
  logic [2:0]  acc_q, acc_d;
  logic [11:0] wy_q, wy_d;
  logic [3:0]  wm_q, wm_d;
  logic [1:0]  wmod4_q, wmod4_d;
  logic [6:0]  wmod100_q, wmod100_d;
  logic [8:0]  wmod400_q, wmod400_d;

  logic        leap_w;
  logic        set_bad;

  assign leap_w = leap_from_mods(wmod4_q, wmod100_q, wmod400_q);

  // Next-state logic: midnight tick, set-date FSM and the epoch walk.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    day_d     = day_q;
    month_d   = month_q;
    year_d    = year_q;
    days_cnt_d = days_cnt_q;
    first_d   = first_q;
    wday_d    = wday_q;
    mod4_d    = mod4_q;
    mod100_d  = mod100_q;
    mod400_d  = mod400_q;
    err_d     = 1'b0;
    pending_d = pending_q;
    sd_d      = sd_q;
    sm_d      = sm_q;
    sy_d      = sy_q;
    acc_d     = acc_q;
    wy_d      = wy_q;
    wm_d      = wm_q;
    wmod4_d   = wmod4_q;
    wmod100_d = wmod100_q;
    wmod400_d = wmod400_q;
    set_bad   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (day_tick_i || pending_q) begin
          wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
          if (day_q < days_cnt_q) begin
            day_d = day_q + 5'd1;
          end else begin
            day_d   = 5'd1;
            first_d = add_mod7(first_q, len_mod7(days_cnt_q));
            if (month_q == 4'd11) begin
              month_d = 4'd0;
              if (year_q == Y_MAX) begin
                year_d   = Y_MIN;
                mod4_d   = MIN_MOD4;
                mod100_d = MIN_MOD100;
                mod400_d = MIN_MOD400;
                first_d  = EPOCH;
                wday_d   = EPOCH;
              end else begin
                year_d   = year_q + 12'd1;
                mod4_d   = mod4_q + 2'd1;
                mod100_d = inc_mod100(mod100_q);
                mod400_d = inc_mod400(mod400_q);
              end
            end else begin
              month_d = month_q + 4'd1;
            end
            days_cnt_d = month_len(month_d, leap_from_mods(mod4_d, mod100_d, mod400_d));
          end
        end
        // A stored tick and a fresh one in the same cycle: the fresh one waits a cycle.
        pending_d = pending_q && day_tick_i;
        if (set_valid_i) begin
          sd_d      = set_day_i;
          sm_d      = set_month_i;
          sy_d      = set_year_i;
          acc_d     = EPOCH;
          wy_d      = Y_MIN;
          wm_d      = 4'd0;
          wmod4_d   = MIN_MOD4;
          wmod100_d = MIN_MOD100;
          wmod400_d = MIN_MOD400;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        set_bad = (sy_q < Y_MIN) || (sy_q > Y_MAX) || (sm_q > 4'd11) || (sd_q == 5'd0) ||
                  (sd_q > month_len(sm_q, leap_of_year(sy_q)));
        if (set_bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (sy_q != Y_MIN) begin
          state_d = S_WALK_Y;
        end else if (sm_q != 4'd0) begin
          state_d = S_WALK_M;
        end else begin
          state_d = S_COMMIT;
        end
      end

      S_WALK_Y: begin
        // 365 = 1 mod 7, 366 = 2 mod 7
        acc_d     = add_mod7(acc_q, leap_w ? 3'd2 : 3'd1);
        wy_d      = wy_q + 12'd1;
        wmod4_d   = wmod4_q + 2'd1;
        wmod100_d = inc_mod100(wmod100_q);
        wmod400_d = inc_mod400(wmod400_q);
        if (wy_d == sy_q) state_d = (sm_q != 4'd0) ? S_WALK_M : S_COMMIT;
      end

      S_WALK_M: begin
        // Walk counters now hold the target year, so leap_w is its leap flag.
        acc_d = add_mod7(acc_q, len_mod7(month_len(wm_q, leap_w)));
        wm_d  = wm_q + 4'd1;
        if (wm_d == sm_q) state_d = S_COMMIT;
      end

      S_COMMIT: begin
        day_d      = sd_q;
        month_d    = sm_q;
        year_d     = sy_q;
        days_cnt_d = month_len(sm_q, leap_w);
        mod4_d     = wmod4_q;
        mod100_d   = wmod100_q;
        mod400_d   = wmod400_q;
        first_d    = acc_q;
        wday_d     = mod7_small(6'(acc_q) + 6'(sd_q) - 6'd1);
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Ticks arriving while busy are remembered once; extras are dropped.
    if (state_q != S_IDLE && day_tick_i) pending_d = 1'b1;
  end

  assign busy_d = (state_d != S_IDLE);

  // State registers; every register returns to the reset date.
  always_ff @(posedge clk_50_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      day_q      <= 5'd1;
      month_q    <= 4'd0;
      year_q     <= Y_MIN;
      days_cnt_q <= 5'd31;
      first_q    <= EPOCH;
      wday_q     <= EPOCH;
      mod4_q     <= MIN_MOD4;
      mod100_q   <= MIN_MOD100;
      mod400_q   <= MIN_MOD400;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      sd_q       <= 5'd0;
      sm_q       <= 4'd0;
      sy_q       <= 12'd0;
      acc_q      <= EPOCH;
      wy_q       <= Y_MIN;
      wm_q       <= 4'd0;
      wmod4_q    <= MIN_MOD4;
      wmod100_q  <= MIN_MOD100;
      wmod400_q  <= MIN_MOD400;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      days_cnt_q <= days_cnt_d;
      first_q    <= first_d;
      wday_q     <= wday_d;
      mod4_q     <= mod4_d;
      mod100_q   <= mod100_d;
      mod400_q   <= mod400_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      sd_q       <= sd_d;
      sm_q       <= sm_d;
      sy_q       <= sy_d;
      acc_q      <= acc_d;
      wy_q       <= wy_d;
      wm_q       <= wm_d;
      wmod4_q    <= wmod4_d;
      wmod100_q  <= wmod100_d;
      wmod400_q  <= wmod400_d;
    end
  end

  assign set_ready_o       = !busy_q;
  assign busy_o            = busy_q;
  assign set_err_o         = err_q;
  assign day_in_month_o    = day_q;
  assign month_o           = month_q;
  assign year_o            = year_q;
  assign month_days_cnt_o  = days_cnt_q;
  assign month_first_day_o = first_q;
  assign week_day_o        = wday_q;

endmodule

// File: tb/tb_cal_date_keeper.sv
// Directed bench for cal_date_keeper: reset, ticks, set-date walk timing,
// invalid dates, ticks during a walk, end-of-range wrap and reset mid-walk.
module tb_cal_date_keeper;

  logic        clk_50_i;
  logic        rst_i;
  logic        day_tick_i;
  logic        set_valid_i;
  logic        set_ready_o;
  logic [4:0]  set_day_i;
  logic [3:0]  set_month_i;
  logic [11:0] set_year_i;
  logic        set_err_o;
  logic        busy_o;
  logic [4:0]  day_in_month_o;
  logic [3:0]  month_o;
  logic [11:0] year_o;
  logic [4:0]  month_days_cnt_o;
  logic [2:0]  month_first_day_o;
  logic [2:0]  week_day_o;

  int checks = 0;
  int errors = 0;
  int n;

  cal_date_keeper dut (
    .clk_50_i          (clk_50_i),
    .rst_i             (rst_i),
    .day_tick_i        (day_tick_i),
    .set_valid_i       (set_valid_i),
    .set_ready_o       (set_ready_o),
    .set_day_i         (set_day_i),
    .set_month_i       (set_month_i),
    .set_year_i        (set_year_i),
    .set_err_o         (set_err_o),
    .busy_o            (busy_o),
    .day_in_month_o    (day_in_month_o),
    .month_o           (month_o),
    .year_o            (year_o),
    .month_days_cnt_o  (month_days_cnt_o),
    .month_first_day_o (month_first_day_o),
    .week_day_o        (week_day_o)
  );

  initial clk_50_i = 1'b0;
  always #10 clk_50_i = ~clk_50_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y,
                            input int cnt, input int first, input int wd);
    check({tag, ".day"},   32'(day_in_month_o),    d);
    check({tag, ".month"}, 32'(month_o),           m);
    check({tag, ".year"},  32'(year_o),            y);
    check({tag, ".dcnt"},  32'(month_days_cnt_o),  cnt);
    check({tag, ".first"}, 32'(month_first_day_o), first);
    check({tag, ".wday"},  32'(week_day_o),        wd);
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk_50_i);
    #1;
  endtask

  task automatic tick();
    day_tick_i = 1'b1;
    step();
    day_tick_i = 1'b0;
  endtask

  // Present a request; returns just after the acceptance edge T.
  task automatic do_set(input int d, input int m, input int y);
    set_day_i   = 5'(d);
    set_month_i = 4'(m);
    set_year_i  = 12'(y);
    set_valid_i = 1'b1;
    step();
    set_valid_i = 1'b0;
  endtask

  // Step until busy drops; cnt = further edges taken. Expiry counts as a failure.
  task automatic wait_idle(input string tag, input int budget, output int cnt);
    cnt = 0;
    while (busy_o === 1'b1 && cnt < budget) begin
      step();
      cnt++;
    end
    check({tag, ".idle_timeout"}, 32'(busy_o), 0);
  endtask

  task automatic expect_reject(input string tag, input int d, input int m, input int y);
    do_set(d, m, y);
    check({tag, ".busy_T1"}, 32'(busy_o), 1);
    check({tag, ".err_T1"},  32'(set_err_o), 0);
    step();
    check({tag, ".err_T2"},  32'(set_err_o), 1);
    check({tag, ".busy_T2"}, 32'(busy_o), 0);
    step();
    check({tag, ".err_T3"},  32'(set_err_o), 0);
  endtask

  initial begin
    rst_i       = 1'b0;
    day_tick_i  = 1'b0;
    set_valid_i = 1'b0;
    set_day_i   = '0;
    set_month_i = '0;
    set_year_i  = '0;
    repeat (3) step();

    // Reset state: 1 Jan 2000, Saturday.
    check_date("reset", 1, 0, 2000, 31, 5, 5);
    check("reset.ready", 32'(set_ready_o), 1);
    check("reset.busy",  32'(busy_o), 0);
    check("reset.err",   32'(set_err_o), 0);
    rst_i = 1'b1;
    step();
    check_date("post_reset", 1, 0, 2000, 31, 5, 5);

    // Plain tick in IDLE.
    tick();
    check_date("tick1", 2, 0, 2000, 31, 5, 6);

    // 31 Jan 2000 (Monday): no walk, outputs two edges after acceptance.
    do_set(31, 0, 2000);
    check("jan31.busy_T1", 32'(busy_o), 1);
    check("jan31.ready_T1", 32'(set_ready_o), 0);
    wait_idle("jan31", 50, n);
    check("jan31.latency", 32'(n), 2);
    check_date("jan31", 31, 0, 2000, 31, 5, 0);
    tick();
    check_date("feb1_2000", 1, 1, 2000, 29, 1, 1);

    // 15 Mar 2024 (Friday): Ny=24, M=2, outputs 28 edges after acceptance.
    do_set(15, 2, 2024);
    repeat (27) step();
    check("mar2024.busy_27", 32'(busy_o), 1);
    check("mar2024.month_27", 32'(month_o), 1);
    wait_idle("mar2024", 50, n);
    check("mar2024.latency", 32'(n), 1);
    check_date("mar2024", 15, 2, 2024, 31, 4, 4);

    // Rejected requests leave the date alone.
    expect_reject("feb29_2023", 29, 1, 2023);
    check_date("after_rej", 15, 2, 2024, 31, 4, 4);
    expect_reject("year_1999", 1, 0, 1999);
    expect_reject("month_12", 1, 12, 2000);
    expect_reject("day_0", 0, 3, 2001);
    expect_reject("feb29_2100", 29, 1, 2100);
    check_date("after_rej2", 15, 2, 2024, 31, 4, 4);

    // 29 Feb 2000 accepted (Tuesday); 28 Feb 2100 has a 28-day month (Sunday).
    do_set(29, 1, 2000);
    wait_idle("feb29_2000", 50, n);
    check_date("feb29_2000", 29, 1, 2000, 29, 1, 1);
    do_set(28, 1, 2100);
    wait_idle("feb28_2100", 200, n);
    check("feb28_2100.latency", 32'(n), 103);
    check_date("feb28_2100", 28, 1, 2100, 28, 0, 6);

    // 31 Dec 2100 (Friday) with two ticks during the walk: only one survives.
    do_set(31, 11, 2100);
    repeat (5) step();
    tick();
    repeat (5) step();
    tick();
    check("dec2100.busy", 32'(busy_o), 1);
    wait_idle("dec2100", 300, n);
    check_date("dec2100", 31, 11, 2100, 31, 2, 4);
    step();
    check_date("jan2101", 1, 0, 2101, 31, 5, 5);
    repeat (3) step();
    check_date("jan2101_hold", 1, 0, 2101, 31, 5, 5);

    // Tick coincident with acceptance: tick applies, set overrides at commit.
    day_tick_i = 1'b1;
    do_set(10, 0, 2000);
    day_tick_i = 1'b0;
    check("coinc.tick_applied", 32'(day_in_month_o), 2);
    wait_idle("coinc", 50, n);
    check_date("coinc", 10, 0, 2000, 31, 5, 0);
    step();
    check("coinc.no_extra", 32'(day_in_month_o), 10);

    // Last representable date wraps to the epoch.
    do_set(31, 11, 2999);
    wait_idle("dec2999", 1200, n);
    check("dec2999.day",  32'(day_in_month_o), 31);
    check("dec2999.year", 32'(year_o), 2999);
    tick();
    check_date("wrap", 1, 0, 2000, 31, 5, 5);

    // Reset mid-walk with a pending tick: everything returns to reset values.
    do_set(15, 2, 2024);
    repeat (5) step();
    tick();
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    check_date("midrst", 1, 0, 2000, 31, 5, 5);
    check("midrst.busy",  32'(busy_o), 0);
    check("midrst.ready", 32'(set_ready_o), 1);
    step();
    rst_i = 1'b1;
    repeat (3) step();
    check_date("midrst_rel", 1, 0, 2000, 31, 5, 5);
    check("midrst_rel.busy", 32'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
